// File: rtl/vga_bram_arb_pkg.sv
// Shared types, constants and helpers for the VGA BRAM port-B arbiter.
package vga_bram_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NUM_WE = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RD_LAT = 2;

  typedef enum logic {
    OWNER_R0 = 1'b0,
    OWNER_R1 = 1'b1
  } owner_e;

  // One entry of the read-return tracking pipeline.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  // Word-aligned byte address inside a power-of-two sized memory.
  function automatic logic [ADDR_W-1:0] byte_addr_mask(input logic [ADDR_W-1:0] addr,
                                                       input int unsigned        memsize);
    byte_addr_mask = addr & ADDR_W'(memsize - 1) & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/vga_bram_port_arbiter_if.sv
// Requester and BRAM port-B signal bundle for the arbiter.
interface vga_bram_port_arbiter_if
  import vga_bram_arb_pkg::*;
#(
  parameter int unsigned C_PORT_DWIDTH = DATA_W,
  parameter int unsigned C_PORT_AWIDTH = ADDR_W,
  parameter int unsigned C_NUM_WE      = NUM_WE
);

  logic                     R0_Req;
  logic [C_PORT_AWIDTH-1:0] R0_Addr;
  logic                     R0_Ack;
  logic [C_PORT_DWIDTH-1:0] R0_RdData;
  logic                     R0_RdValid;

  logic                     R1_Req;
  logic [C_NUM_WE-1:0]      R1_WE;
  logic [C_PORT_AWIDTH-1:0] R1_Addr;
  logic [C_PORT_DWIDTH-1:0] R1_WrData;
  logic                     R1_Ack;
  logic [C_PORT_DWIDTH-1:0] R1_RdData;
  logic                     R1_RdValid;

  logic                     BRAM_Rst_B;
  logic                     BRAM_Clk_B;
  logic                     BRAM_EN_B;
  logic [C_NUM_WE-1:0]      BRAM_WEN_B;
  logic [C_PORT_AWIDTH-1:0] BRAM_Addr_B;
  logic [C_PORT_DWIDTH-1:0] BRAM_Dout_B;
  logic [C_PORT_DWIDTH-1:0] BRAM_Din_B;

  // Arbiter view.
  modport slave (
    input  R0_Req, R0_Addr, R1_Req, R1_WE, R1_Addr, R1_WrData, BRAM_Din_B,
    output R0_Ack, R0_RdData, R0_RdValid, R1_Ack, R1_RdData, R1_RdValid,
           BRAM_Rst_B, BRAM_Clk_B, BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B
  );

  // Requesters and memory view.
  modport master (
    output R0_Req, R0_Addr, R1_Req, R1_WE, R1_Addr, R1_WrData, BRAM_Din_B,
    input  R0_Ack, R0_RdData, R0_RdValid, R1_Ack, R1_RdData, R1_RdValid,
           BRAM_Rst_B, BRAM_Clk_B, BRAM_EN_B, BRAM_WEN_B, BRAM_Addr_B, BRAM_Dout_B
  );

endinterface

// File: rtl/vga_bram_fair_counter.sv
// Saturating count of consecutive R0 grants taken while R1 is waiting.
module vga_bram_fair_counter
  import vga_bram_arb_pkg::*;
#(
  parameter int unsigned C_R0_MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic r0_grant,
  input  logic r1_grant,
  input  logic r1_req,
  output logic limit_hit
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(C_R0_MAX_BURST);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Clear when R1 is served or idle, otherwise count R0 grants up to the limit.
  always_comb begin
    cnt_nxt_c = cnt;
    if (!r1_req || r1_grant) begin
      cnt_nxt_c = '0;
    end else if (r0_grant && (cnt != MAX_CNT)) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  // Counter and its limit flag, both registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      limit_hit <= 1'b0;
    end else begin
      cnt       <= cnt_nxt_c;
      limit_hit <= (cnt_nxt_c == MAX_CNT);
    end
  end

endmodule

// File: rtl/vga_bram_port_arbiter.sv
// Shares BRAM port B between the scan-out reader (R0) and a command master (R1).
module vga_bram_port_arbiter
  import vga_bram_arb_pkg::*;
#(
  parameter int unsigned C_MEMSIZE      = 32'h8000,
  parameter int unsigned C_PORT_DWIDTH  = DATA_W,
  parameter int unsigned C_PORT_AWIDTH  = ADDR_W,
  parameter int unsigned C_NUM_WE       = NUM_WE,
  parameter int unsigned C_R0_MAX_BURST = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  vga_bram_port_arbiter_if.slave bus
);

  logic                   r0_elig_c;
  logic                   r1_elig_c;
  logic                   r0_grant_c;
  logic                   r1_grant_c;
  logic                   limit_hit;
  rd_tag_t                issue_tag_c;
  rd_tag_t [RD_LAT-1:0]   rd_pipe;

  assign bus.BRAM_Rst_B = Rst;
  assign bus.BRAM_Clk_B = Clk;

  // A request is ignored while its own Ack is high; R1 wins only alone or at the burst limit.
  always_comb begin
    r0_elig_c         = bus.R0_Req & ~bus.R0_Ack;
    r1_elig_c         = bus.R1_Req & ~bus.R1_Ack;
    r1_grant_c        = r1_elig_c & (~r0_elig_c | limit_hit);
    r0_grant_c        = r0_elig_c & ~r1_grant_c;
    issue_tag_c.valid = r0_grant_c | (r1_grant_c & (bus.R1_WE == '0));
    issue_tag_c.owner = r1_grant_c ? OWNER_R1 : OWNER_R0;
  end

  vga_bram_fair_counter #(
    .C_R0_MAX_BURST(C_R0_MAX_BURST)
  ) u_fair_counter (
    .clk      (Clk),
    .rst      (Rst),
    .r0_grant (r0_grant_c),
    .r1_grant (r1_grant_c),
    .r1_req   (bus.R1_Req),
    .limit_hit(limit_hit)
  );

  // Issue the granted access on port B one cycle after the decision.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.R0_Ack      <= 1'b0;
      bus.R1_Ack      <= 1'b0;
      bus.BRAM_EN_B   <= 1'b0;
      bus.BRAM_WEN_B  <= '0;
      bus.BRAM_Addr_B <= '0;
      bus.BRAM_Dout_B <= '0;
    end else begin
      bus.R0_Ack     <= r0_grant_c;
      bus.R1_Ack     <= r1_grant_c;
      bus.BRAM_EN_B  <= r0_grant_c | r1_grant_c;
      bus.BRAM_WEN_B <= '0;
      if (r1_grant_c) begin
        bus.BRAM_WEN_B  <= C_NUM_WE'(bus.R1_WE);
        bus.BRAM_Addr_B <= C_PORT_AWIDTH'(byte_addr_mask(ADDR_W'(bus.R1_Addr), C_MEMSIZE));
        bus.BRAM_Dout_B <= C_PORT_DWIDTH'(bus.R1_WrData);
      end else if (r0_grant_c) begin
        bus.BRAM_Addr_B <= C_PORT_AWIDTH'(byte_addr_mask(ADDR_W'(bus.R0_Addr), C_MEMSIZE));
      end
    end
  end

  // Track read owners alongside the BRAM latency and steer returned data.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rd_pipe        <= '0;
      bus.R0_RdValid <= 1'b0;
      bus.R1_RdValid <= 1'b0;
      bus.R0_RdData  <= '0;
      bus.R1_RdData  <= '0;
    end else begin
      rd_pipe        <= {rd_pipe[RD_LAT-2:0], issue_tag_c};
      bus.R0_RdValid <= rd_pipe[RD_LAT-1].valid && (rd_pipe[RD_LAT-1].owner == OWNER_R0);
      bus.R1_RdValid <= rd_pipe[RD_LAT-1].valid && (rd_pipe[RD_LAT-1].owner == OWNER_R1);
      if (rd_pipe[RD_LAT-1].valid) begin
        if (rd_pipe[RD_LAT-1].owner == OWNER_R0) begin
          bus.R0_RdData <= C_PORT_DWIDTH'(bus.BRAM_Din_B);
        end else begin
          bus.R1_RdData <= C_PORT_DWIDTH'(bus.BRAM_Din_B);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_bram_port_arbiter.sv
// Randomized and directed bench for vga_bram_port_arbiter against a transaction-level model.
module tb_vga_bram_port_arbiter;

  localparam int unsigned MEMSIZE   = 32'h8000;
  localparam int unsigned WORDS     = MEMSIZE / 4;
  localparam int unsigned MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_bram_port_arbiter_if bus ();

  vga_bram_port_arbiter #(
    .C_MEMSIZE     (MEMSIZE),
    .C_R0_MAX_BURST(MAX_BURST)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  // Byte-lane merge: lane b of the enable covers data bits [8b+7:8b].
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] we);
    merge_bytes = old;
    for (int b = 0; b < 4; b++) if (we[b]) merge_bytes[8*b +: 8] = wd[8*b +: 8];
  endfunction

  // Behavioural BRAM port B: one-cycle read latency.
  logic [31:0] bram_mem [WORDS];
  logic [31:0] bram_dout = '0;
  logic [31:0] bram_a;
  logic [3:0]  bram_we;
  logic [31:0] bram_wd;
  assign bram_a  = bus.BRAM_Addr_B;
  assign bram_we = bus.BRAM_WEN_B;
  assign bram_wd = bus.BRAM_Dout_B;
  assign bus.BRAM_Din_B = bram_dout;

  always @(posedge clk) begin
    if (bus.BRAM_EN_B) begin
      bram_dout <= bram_mem[bram_a[14:2]];
      if (bram_we != 4'd0) bram_mem[bram_a[14:2]] <= merge_bytes(bram_mem[bram_a[14:2]], bram_wd, bram_we);
    end
  end

  // Held requests must keep their address and payload until acknowledged.
  a_r0_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.R0_Req && !bus.R0_Ack) |=> (bus.R0_Ack || $stable(bus.R0_Addr)));
  a_r1_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.R1_Req && !bus.R1_Ack) |=> (bus.R1_Ack || ($stable(bus.R1_Addr) && $stable(bus.R1_WE)
                                                    && $stable(bus.R1_WrData))));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model state: expected outputs now (m_) and after the next edge (nx_).
  typedef struct {
    int          due;
    bit          owner;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     rdq[$];
  logic [31:0] ref_mem [WORDS];
  int          burst = 0;
  bit          m_ack0 = 0, m_ack1 = 0, m_en = 0, m_rdv0 = 0, m_rdv1 = 0;
  bit          nx_ack0 = 0, nx_ack1 = 0, nx_en = 0, nx_rst = 0;
  logic [3:0]  m_wen = '0, nx_wen = '0;
  logic [31:0] m_addr = '0, m_dout = '0, nx_addr = '0, nx_dout = '0, m_rdd0 = '0, m_rdd1 = '0;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return (a % MEMSIZE) / 4 * 4;
  endfunction

  // Apply the grant rules to the inputs of the current cycle.
  task automatic model_decide();
    bit          e0, e1, g0, g1;
    logic [31:0] a;
    logic [12:0] idx;
    nx_rst = rst;
    if (rst) begin
      burst = 0;
      rdq.delete();
      nx_ack0 = 0; nx_ack1 = 0; nx_en = 0; nx_wen = '0; nx_addr = '0; nx_dout = '0;
      return;
    end
    e0 = bus.R0_Req && !m_ack0;
    e1 = bus.R1_Req && !m_ack1;
    g1 = e1 && (!e0 || burst == int'(MAX_BURST));
    g0 = e0 && !g1;
    if (!bus.R1_Req || g1) burst = 0;
    else if (g0 && burst < int'(MAX_BURST)) burst++;
    nx_ack0 = g0; nx_ack1 = g1; nx_en = g0 || g1;
    nx_wen = '0; nx_addr = m_addr; nx_dout = m_dout;
    if (g0) begin
      a = word_addr(bus.R0_Addr);
      idx = 13'(a / 4);
      nx_addr = a;
      rdq.push_back('{cyc + 3, 1'b0, ref_mem[idx]});
    end
    if (g1) begin
      a = word_addr(bus.R1_Addr);
      idx = 13'(a / 4);
      nx_addr = a;
      nx_wen  = bus.R1_WE;
      nx_dout = bus.R1_WrData;
      if (bus.R1_WE == 4'd0) rdq.push_back('{cyc + 3, 1'b1, ref_mem[idx]});
      else ref_mem[idx] = merge_bytes(ref_mem[idx], bus.R1_WrData, bus.R1_WE);
    end
  endtask

  task automatic advance_and_compare();
    m_ack0 = nx_ack0; m_ack1 = nx_ack1; m_en = nx_en;
    m_wen = nx_wen; m_addr = nx_addr; m_dout = nx_dout;
    m_rdv0 = 0; m_rdv1 = 0;
    if (nx_rst) begin
      m_rdd0 = '0; m_rdd1 = '0;
    end else if (rdq.size() > 0 && rdq[0].due == cyc) begin
      if (rdq[0].owner) begin m_rdv1 = 1; m_rdd1 = rdq[0].data; end
      else begin m_rdv0 = 1; m_rdd0 = rdq[0].data; end
      void'(rdq.pop_front());
    end
    check_val("r0_ack", 32'(bus.R0_Ack), 32'(m_ack0));
    check_val("r1_ack", 32'(bus.R1_Ack), 32'(m_ack1));
    check_val("en", 32'(bus.BRAM_EN_B), 32'(m_en));
    check_val("wen", 32'(bus.BRAM_WEN_B), 32'(m_wen));
    check_val("r0_rdvalid", 32'(bus.R0_RdValid), 32'(m_rdv0));
    check_val("r1_rdvalid", 32'(bus.R1_RdValid), 32'(m_rdv1));
    check_val("r0_rddata", bus.R0_RdData, m_rdd0);
    check_val("r1_rddata", bus.R1_RdData, m_rdd1);
    check_val("bram_rst", 32'(bus.BRAM_Rst_B), 32'(rst));
    if (m_en || nx_rst) check_val("addr", bus.BRAM_Addr_B, m_addr);
    if ((m_en && m_wen != 4'd0) || nx_rst) check_val("dout", bus.BRAM_Dout_B, m_dout);
  endtask

  task automatic tick();
    model_decide();
    @(posedge clk);
    #1;
    cyc++;
    advance_and_compare();
  endtask

  // One directed access; reports the returned read data and the Ack-to-RdValid latency.
  task automatic access(input bit who, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, output logic [31:0] rd, output bit got,
                        output int lat);
    bit acked;
    acked = 0; rd = '0; got = 0; lat = 0;
    if (!who) begin
      bus.R0_Req = 1; bus.R0_Addr = addr;
    end else begin
      bus.R1_Req = 1; bus.R1_Addr = addr; bus.R1_WE = we; bus.R1_WrData = wd;
    end
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      acked = who ? bus.R1_Ack : bus.R0_Ack;
    end
    bus.R0_Req = 0; bus.R1_Req = 0;
    check_val(who ? "r1_ack_seen" : "r0_ack_seen", 32'(acked), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!got && (who ? bus.R1_RdValid : bus.R0_RdValid)) begin
        got = 1; lat = k;
        rd = who ? bus.R1_RdData : bus.R0_RdData;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a |= $urandom() & 32'hFFFF_8000;
    return a;
  endfunction

  task automatic drive_r0();
    if (!bus.R0_Req || bus.R0_Ack) begin
      bus.R0_Req = ($urandom_range(0, 2) != 0);
      if (bus.R0_Req) bus.R0_Addr = rand_addr();
    end
  endtask

  task automatic drive_r1();
    if (!bus.R1_Req || bus.R1_Ack) begin
      bus.R1_Req = ($urandom_range(0, 2) != 0);
      if (bus.R1_Req) begin
        bus.R1_Addr    = rand_addr();
        bus.R1_WE      = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
        bus.R1_WrData  = $urandom();
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    bit          got, acked, seen;
    int          lat, elig;

    for (int i = 0; i < int'(WORDS); i++) begin
      bram_mem[13'(i)] = $urandom();
      ref_mem[13'(i)]  = bram_mem[13'(i)];
    end
    bus.R0_Req = 0; bus.R0_Addr = '0;
    bus.R1_Req = 0; bus.R1_Addr = '0; bus.R1_WE = '0; bus.R1_WrData = '0;

    // Reset held three cycles, then idle.
    rst = 1;
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    check_val("rst_en", 32'(bus.BRAM_EN_B), 32'd0);
    check_val("rst_addr", bus.BRAM_Addr_B, 32'd0);
    check_val("rst_dout", bus.BRAM_Dout_B, 32'd0);
    check_val("rst_r0_data", bus.R0_RdData, 32'd0);

    // R0 single read.
    bram_mem[13'h4] = 32'hDEADBEEF; ref_mem[13'h4] = 32'hDEADBEEF;
    access(1'b0, 32'h10, 4'd0, 32'd0, d, got, lat);
    check_val("r0_read_data", d, 32'hDEADBEEF);
    check_val("r0_read_lat", 32'(lat), 32'd2);

    // R1 full write, readback, then single-lane write, readback.
    access(1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, d, got, lat);
    check_val("r1_wr_no_rdvalid", 32'(got), 32'd0);
    access(1'b1, 32'h20, 4'b0000, 32'd0, d, got, lat);
    check_val("r1_rd_full", d, 32'hCAFEF00D);
    check_val("r1_rd_lat", 32'(lat), 32'd2);
    access(1'b1, 32'h20, 4'b1000, 32'h11223344, d, got, lat);
    access(1'b1, 32'h20, 4'b0000, 32'd0, d, got, lat);
    check_val("r1_rd_lane", d, 32'h11FEF00D);

    // Both requesting continuously: R1 must be served within its burst window.
    bus.R0_Req = 1; bus.R0_Addr = rand_addr();
    bus.R1_Req = 1; bus.R1_Addr = rand_addr(); bus.R1_WE = '0;
    for (int k = 0; k < 3; k++) begin
      elig = 0; acked = 0;
      for (int i = 0; i < 12 && !acked; i++) begin
        if (!bus.R1_Ack) elig++;
        tick();
        if (bus.R0_Ack) bus.R0_Addr = rand_addr();
        if (bus.R1_Ack) begin acked = 1; bus.R1_Addr = rand_addr(); end
      end
      check_val("r1_starve", 32'(acked && elig <= int'(MAX_BURST) + 1), 32'd1);
    end
    bus.R0_Req = 0; bus.R1_Req = 0;
    repeat (4) tick();

    // Address wrap, then reset the cycle after Ack: the read must never return.
    bus.R0_Req = 1; bus.R0_Addr = 32'h8004;
    acked = 0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      acked = bus.R0_Ack;
    end
    check_val("wrap_ack", 32'(acked), 32'd1);
    check_val("wrap_addr", bus.BRAM_Addr_B, 32'h4);
    bus.R0_Req = 0;
    seen = 0;
    tick();
    seen |= bus.R0_RdValid;
    rst = 1;
    tick();
    seen |= bus.R0_RdValid;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= bus.R0_RdValid;
    end
    check_val("rst_drops_read", 32'(seen), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) begin
        rst = 1; bus.R0_Req = 0; bus.R1_Req = 0;
      end else begin
        drive_r0();
        drive_r1();
      end
      tick();
    end
    bus.R0_Req = 0; bus.R1_Req = 0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
